// File: rtl/ctrl_pipe_unit.sv
// Opcode decoder and ID/EX -> EX/MEM -> MEM/WB control pipeline for the 5-stage MIPS subset,
// with stall/flush bubbles, illegal-opcode pulse and retired-instruction counter.
module ctrl_pipe_unit #(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 3,
  parameter int HAS_LUI  = 1,
  parameter int HAS_JUMP = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [OP_W-1:0]    id_opcode,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic               ex_alusrc,
  output logic               ex_regdst,
  output logic [1:0]         ex_extop,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_jump,
  output logic               mem_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_branch,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired_cnt
);

  typedef struct packed {
    logic               valid;
    logic               alusrc;
    logic               regdst;
    logic [1:0]         extop;
    logic [ALUOP_W-1:0] aluop;
    logic               jump;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               regwrite;
    logic               memtoreg;
  } idex_t;

  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic regwrite;
    logic memtoreg;
  } exmem_t;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memtoreg;
  } memwb_t;

  localparam logic [OP_W-1:0] OP_R     = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b001001);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  idex_t            dec, idex_d, idex_q;
  exmem_t           exmem_d, exmem_q;
  memwb_t           memwb_d, memwb_q;
  logic             legal, ill_d, ill_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (id_opcode)
      OP_R:              begin dec.regdst = 1'b1; dec.aluop = ALUOP_W'(3); dec.regwrite = 1'b1; end
      OP_ADDI, OP_ADDIU: begin dec.alusrc = 1'b1; dec.extop = 2'b01; dec.regwrite = 1'b1; end
      OP_ORI:            begin dec.alusrc = 1'b1; dec.aluop = ALUOP_W'(2); dec.regwrite = 1'b1; end
      OP_LUI: begin
        if (HAS_LUI != 0) begin
          dec.alusrc = 1'b1; dec.extop = 2'b10; dec.aluop = ALUOP_W'(4); dec.regwrite = 1'b1;
        end else legal = 1'b0;
      end
      OP_LW: begin
        dec.alusrc = 1'b1; dec.extop = 2'b01; dec.mem_read = 1'b1;
        dec.memtoreg = 1'b1; dec.regwrite = 1'b1;
      end
      OP_SW:  begin dec.alusrc = 1'b1; dec.extop = 2'b01; dec.mem_write = 1'b1; end
      OP_BEQ: begin dec.extop = 2'b01; dec.aluop = ALUOP_W'(1); dec.branch = 1'b1; end
      OP_J: begin
        if (HAS_JUMP != 0) dec.jump = 1'b1;
        else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    // Invalid or illegal slots travel as all-zero bubbles so valid gates every field.
    if (id_valid && legal) dec.valid = 1'b1;
    else                   dec = '0;
  end

  always_comb begin
    idex_d = (flush || stall) ? '0 : dec;
    ill_d  = !(flush || stall) && id_valid && !legal;

    exmem_d = '0;
    if (!flush) begin
      exmem_d.valid     = idex_q.valid;
      exmem_d.mem_read  = idex_q.mem_read;
      exmem_d.mem_write = idex_q.mem_write;
      exmem_d.branch    = idex_q.branch;
      exmem_d.regwrite  = idex_q.regwrite;
      exmem_d.memtoreg  = idex_q.memtoreg;
    end

    memwb_d.valid    = exmem_q.valid;
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memtoreg;

    cnt_d = cnt_q + CNT_W'(memwb_q.valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid    = idex_q.valid;
  assign ex_alusrc   = idex_q.alusrc;
  assign ex_regdst   = idex_q.regdst;
  assign ex_extop    = idex_q.extop;
  assign ex_aluop    = idex_q.aluop;
  assign ex_jump     = idex_q.jump;
  assign mem_valid   = exmem_q.valid;
  assign mem_read    = exmem_q.mem_read;
  assign mem_write   = exmem_q.mem_write;
  assign mem_branch  = exmem_q.branch;
  assign wb_valid    = memwb_q.valid;
  assign wb_regwrite = memwb_q.regwrite;
  assign wb_memtoreg = memwb_q.memtoreg;
  assign illegal_op  = ill_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: full build (4-bit counter) and a build without lui/j,
// both fed the same stimulus and checked against an independent decode table every cycle.
module tb_ctrl_pipe_unit;

  logic       clk, rst, id_valid, stall, flush;
  logic [5:0] id_opcode;

  logic       ex_valid, ex_alusrc, ex_regdst, ex_jump, mem_valid, mem_read, mem_write, mem_branch;
  logic       wb_valid, wb_regwrite, wb_memtoreg, illegal_op;
  logic [1:0] ex_extop;
  logic [2:0] ex_aluop;
  logic [3:0] retired_cnt;

  logic        m_ex_valid, m_ex_alusrc, m_ex_regdst, m_ex_jump, m_mem_valid, m_mem_read, m_mem_write;
  logic        m_mem_branch, m_wb_valid, m_wb_regwrite, m_wb_memtoreg, m_illegal_op;
  logic [1:0]  m_ex_extop;
  logic [2:0]  m_ex_aluop;
  logic [15:0] m_retired_cnt;

  ctrl_pipe_unit #(.HAS_LUI(1), .HAS_JUMP(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_extop(ex_extop),
    .ex_aluop(ex_aluop), .ex_jump(ex_jump), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_branch(mem_branch), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .illegal_op(illegal_op), .retired_cnt(retired_cnt));

  ctrl_pipe_unit #(.HAS_LUI(0), .HAS_JUMP(0), .CNT_W(16)) u_min (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .stall(stall), .flush(flush),
    .ex_valid(m_ex_valid), .ex_alusrc(m_ex_alusrc), .ex_regdst(m_ex_regdst), .ex_extop(m_ex_extop),
    .ex_aluop(m_ex_aluop), .ex_jump(m_ex_jump), .mem_valid(m_mem_valid), .mem_read(m_mem_read),
    .mem_write(m_mem_write), .mem_branch(m_mem_branch), .wb_valid(m_wb_valid),
    .wb_regwrite(m_wb_regwrite), .wb_memtoreg(m_wb_memtoreg), .illegal_op(m_illegal_op),
    .retired_cnt(m_retired_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic v, alusrc, regdst; logic [1:0] extop; logic [2:0] aluop;
    logic jump, rd, wr, br, rw, m2r, ill;
  } ctl_t;
  typedef struct packed { ctl_t ex, mem, wb; logic [15:0] cnt; } exs_t;
  typedef exs_t [1:0] exp_t;

  logic [8:0]  oex[2];
  logic [3:0]  omem[2];
  logic [2:0]  owb[2];
  logic        oill[2];
  logic [15:0] ocnt[2];
  assign oex[0]  = {ex_valid, ex_alusrc, ex_regdst, ex_extop, ex_aluop, ex_jump};
  assign oex[1]  = {m_ex_valid, m_ex_alusrc, m_ex_regdst, m_ex_extop, m_ex_aluop, m_ex_jump};
  assign omem[0] = {mem_valid, mem_read, mem_write, mem_branch};
  assign omem[1] = {m_mem_valid, m_mem_read, m_mem_write, m_mem_branch};
  assign owb[0]  = {wb_valid, wb_regwrite, wb_memtoreg};
  assign owb[1]  = {m_wb_valid, m_wb_regwrite, m_wb_memtoreg};
  assign oill[0] = illegal_op;
  assign oill[1] = m_illegal_op;
  assign ocnt[0] = {12'd0, retired_cnt};
  assign ocnt[1] = m_retired_cnt;

  int   n_cmp = 0, n_err = 0;
  ctl_t ex_m[2], mem_m[2], wb_m[2];
  int   cnt_m[2];
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t dec(input logic [5:0] op, input logic vld, input bit full);
    ctl_t c = '0;
    bit   ok = 1'b1;
    case (op)
      6'b000000: begin c.regdst = 1; c.aluop = 3; c.rw = 1; end
      6'b001000, 6'b001001: begin c.alusrc = 1; c.extop = 2'b01; c.aluop = 0; c.rw = 1; end
      6'b001101: begin c.alusrc = 1; c.extop = 2'b00; c.aluop = 2; c.rw = 1; end
      6'b001111: if (full) begin c.alusrc = 1; c.extop = 2'b10; c.aluop = 4; c.rw = 1; end else ok = 0;
      6'b100011: begin c.alusrc = 1; c.extop = 2'b01; c.rd = 1; c.m2r = 1; c.rw = 1; end
      6'b101011: begin c.alusrc = 1; c.extop = 2'b01; c.wr = 1; end
      6'b000100: begin c.extop = 2'b01; c.aluop = 1; c.br = 1; end
      6'b000010: if (full) c.jump = 1; else ok = 0;
      default:   ok = 0;
    endcase
    if (vld && ok) c.v = 1;
    else begin
      c = '0;
      c.ill = vld && !ok;
    end
    return c;
  endfunction

  function automatic logic [8:0] pex(input ctl_t c);
    return {c.v, c.alusrc, c.regdst, c.extop, c.aluop, c.jump};
  endfunction
  function automatic logic [3:0] pmem(input ctl_t c); return {c.v, c.rd, c.wr, c.br}; endfunction
  function automatic logic [2:0] pwb(input ctl_t c);  return {c.v, c.rw, c.m2r};      endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      ex_m[k] = '0; mem_m[k] = '0; wb_m[k] = '0; cnt_m[k] = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_ex%0d", tag, k), 32'(oex[k]), 0);
      chk($sformatf("%s_mem%0d", tag, k), 32'(omem[k]), 0);
      chk($sformatf("%s_wb%0d", tag, k), 32'(owb[k]), 0);
      chk($sformatf("%s_ill%0d", tag, k), 32'(oill[k]), 0);
      chk($sformatf("%s_cnt%0d", tag, k), 32'(ocnt[k]), 0);
    end
  endtask

  // Drive one ID slot, push the expected post-edge state, then pop and compare after the edge.
  task automatic step(input logic [5:0] op, input logic vld, input logic st, input logic fl);
    exp_t e;
    id_opcode = op; id_valid = vld; stall = st; flush = fl;
    for (int k = 0; k < 2; k++) begin
      cnt_m[k] = (cnt_m[k] + (wb_m[k].v ? 1 : 0)) % ((k == 0) ? 16 : 65536);
      wb_m[k]  = mem_m[k];
      mem_m[k] = fl ? '0 : ex_m[k];
      ex_m[k]  = (fl || st) ? '0 : dec(op, vld, k == 0);
      e[k].ex = ex_m[k]; e[k].mem = mem_m[k]; e[k].wb = wb_m[k]; e[k].cnt = 16'(cnt_m[k]);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ex%0d op=%0b", k, op), 32'(oex[k]), 32'(pex(e[k].ex)));
      chk($sformatf("mem%0d", k), 32'(omem[k]), 32'(pmem(e[k].mem)));
      chk($sformatf("wb%0d", k), 32'(owb[k]), 32'(pwb(e[k].wb)));
      chk($sformatf("ill%0d op=%0b", k, op), 32'(oill[k]), 32'(e[k].ex.ill));
      chk($sformatf("cnt%0d", k), 32'(ocnt[k]), 32'(e[k].cnt));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  localparam logic [5:0] LW = 6'b100011, RR = 6'b000000, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ORI = 6'b001101, LUI = 6'b001111, JJ = 6'b000010, BAD = 6'b111111;
  localparam logic [5:0] ADDI = 6'b001000, ADDIU = 6'b001001;

  initial begin
    logic [5:0] ops[12];
    ops = '{LW, RR, SW, BEQ, ORI, LUI, JJ, BAD, ADDI, ADDIU, 6'b010101, RR};
    rst = 1'b1; id_valid = 1'b0; id_opcode = '0; stall = 1'b0; flush = 1'b0;
    model_clear();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // lw, R, sw, beq back to back, then drain: counter reaches 4
    step(LW, 1, 0, 0); step(RR, 1, 0, 0); step(SW, 1, 0, 0); step(BEQ, 1, 0, 0);
    idle(4);

    // one-cycle load-use stall between lw and add
    step(LW, 1, 0, 0); step(RR, 1, 1, 0); step(RR, 1, 0, 0);
    idle(4);

    // beq in MEM when flush arrives; two younger ori vanish
    step(BEQ, 1, 0, 0); step(ORI, 1, 0, 0); step(ORI, 1, 0, 1);
    idle(3);
    // same with stall raised concurrently
    step(BEQ, 1, 0, 0); step(ORI, 1, 0, 0); step(ORI, 1, 1, 1);
    idle(3);

    // illegal opcodes; lui/j legal only in the full build
    step(BAD, 1, 0, 0); step(LUI, 1, 0, 0); step(JJ, 1, 0, 0); step(BAD, 0, 0, 0);
    step(BAD, 1, 1, 0); step(LUI, 1, 0, 1);
    idle(4);

    // asynchronous reset mid-stream
    step(LW, 1, 0, 0); step(RR, 1, 0, 0);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // 17 retirements wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) step(RR, 1, 0, 0);
    idle(4);

    // random mix
    for (int i = 0; i < 60; i++)
      step(ops[$urandom_range(11)], 1'($urandom_range(3) != 0),
           1'($urandom_range(4) == 0), 1'($urandom_range(6) == 0));
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
